// File: rtl/mult_div_unit.sv
// rtl/mult_div_unit.sv - iterative radix-2 MIPS HI/LO multiply/divide unit
//
// Ports:
//   clk, reset              clock; synchronous active-high reset
//   Start_in, Op_in         launch MULT(00)/MULTU(01)/DIV(10)/DIVU(11) when idle
//   A_in, B_in              rs / rt operands, sampled on the accept edge
//   WriteHI_in, WriteLO_in  MTHI / MTLO strobes, honoured only when idle
//   Data_in                 MTHI / MTLO data
//   Busy_out                high while an operation is in flight
//   Done_out                one-cycle pulse after HI/LO take an operation result
//   HI_out, LO_out          architectural HI / LO registers

module mult_div_unit #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             Start_in,
    input  logic [1:0]       Op_in,
    input  logic [WIDTH-1:0] A_in,
    input  logic [WIDTH-1:0] B_in,
    input  logic             WriteHI_in,
    input  logic             WriteLO_in,
    input  logic [WIDTH-1:0] Data_in,
    output logic             Busy_out,
    output logic             Done_out,
    output logic [WIDTH-1:0] HI_out,
    output logic [WIDTH-1:0] LO_out
);

    localparam int CW = $clog2(WIDTH + 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        FIX  = 2'd2
    } state_t;

    state_t state, state_next;

    logic [CW-1:0]      cnt;
    logic [1:0]         op;
    logic [WIDTH-1:0]   opnd;      // multiplicand (multiply) or divisor (divide) magnitude
    logic [WIDTH-1:0]   a_raw;     // dividend as sampled, returned in HI on divide by zero
    logic [WIDTH-1:0]   rem;       // partial remainder
    logic [2*WIDTH-1:0] acc;       // multiply: {partial sum, multiplier}; divide: low half = dividend/quotient
    logic               neg_res;
    logic               neg_rem;

    logic [WIDTH-1:0]   a_mag, b_mag;
    logic [WIDTH:0]     mul_sum;
    logic [WIDTH:0]     div_shift;
    logic               div_ge;
    logic [WIDTH-1:0]   div_rem_next;
    logic [2*WIDTH-1:0] prod_fix;
    logic [WIDTH-1:0]   quo_fix, rem_fix;

    assign Busy_out = (state != IDLE);

    // Op_in[0]=0 marks the signed variants. The most-negative value negates to
    // itself, which is still the correct unsigned magnitude.
    always_comb begin
        a_mag = (!Op_in[0] && A_in[WIDTH-1]) ? -A_in : A_in;
        b_mag = (!Op_in[0] && B_in[WIDTH-1]) ? -B_in : B_in;
    end

    // One iteration of each algorithm.
    always_comb begin
        mul_sum      = {1'b0, acc[2*WIDTH-1:WIDTH]} + (acc[0] ? {1'b0, opnd} : '0);
        div_shift    = {rem, acc[WIDTH-1]};
        div_ge       = (div_shift >= {1'b0, opnd});
        // When div_ge holds the difference is below the divisor, so it fits WIDTH bits.
        div_rem_next = div_ge ? WIDTH'(div_shift - {1'b0, opnd}) : div_shift[WIDTH-1:0];
    end

    // Sign correction applied on the FIX edge.
    always_comb begin
        prod_fix = neg_res ? -acc : acc;
        quo_fix  = neg_res ? -acc[WIDTH-1:0] : acc[WIDTH-1:0];
        rem_fix  = neg_rem ? -rem : rem;
    end

    always_ff @(posedge clk) begin
        if (reset) state <= IDLE;
        else       state <= state_next;
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (Start_in) state_next = RUN;
            RUN:     if (cnt == CW'(WIDTH - 1)) state_next = FIX;
            FIX:     state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            cnt      <= '0;
            op       <= '0;
            opnd     <= '0;
            a_raw    <= '0;
            rem      <= '0;
            acc      <= '0;
            neg_res  <= 1'b0;
            neg_rem  <= 1'b0;
            HI_out   <= '0;
            LO_out   <= '0;
            Done_out <= 1'b0;
        end else begin
            Done_out <= (state == FIX);
            case (state)
                IDLE: begin
                    if (Start_in) begin
                        op      <= Op_in;
                        a_raw   <= A_in;
                        cnt     <= '0;
                        rem     <= '0;
                        neg_res <= !Op_in[0] && (A_in[WIDTH-1] ^ B_in[WIDTH-1]);
                        neg_rem <= !Op_in[0] && A_in[WIDTH-1];
                        if (Op_in[1]) begin
                            opnd <= b_mag;
                            acc  <= {{WIDTH{1'b0}}, a_mag};
                        end else begin
                            opnd <= a_mag;
                            acc  <= {{WIDTH{1'b0}}, b_mag};
                        end
                    end
                end
                RUN: begin
                    cnt <= cnt + CW'(1);
                    if (op[1]) begin
                        rem            <= div_rem_next;
                        acc[WIDTH-1:0] <= {acc[WIDTH-2:0], div_ge};
                    end else begin
                        acc <= {mul_sum, acc[WIDTH-1:1]};
                    end
                end
                FIX: begin
                    if (op[1]) begin
                        if (opnd == '0) begin
                            LO_out <= '1;
                            HI_out <= a_raw;
                        end else begin
                            LO_out <= quo_fix;
                            HI_out <= rem_fix;
                        end
                    end else begin
                        HI_out <= prod_fix[2*WIDTH-1:WIDTH];
                        LO_out <= prod_fix[WIDTH-1:0];
                    end
                end
                default: ;
            endcase
            // Busy_out is high in FIX, so these never collide with the result write.
            if (!Busy_out) begin
                if (WriteHI_in) HI_out <= Data_in;
                if (WriteLO_in) LO_out <= Data_in;
            end
        end
    end

endmodule

// File: tb/tb_mult_div_unit.sv
// tb/tb_mult_div_unit.sv - self-checking bench for mult_div_unit

module tb_mult_div_unit;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        start = 1'b0;
    logic [1:0]  op = 2'b00;
    logic [31:0] a = '0;
    logic [31:0] b = '0;
    logic        write_hi = 1'b0;
    logic        write_lo = 1'b0;
    logic [31:0] data = '0;
    logic        busy, done;
    logic [31:0] hi, lo;

    int checks = 0;
    int errors = 0;

    mult_div_unit #(.WIDTH(32)) dut (
        .clk        (clk),
        .reset      (reset),
        .Start_in   (start),
        .Op_in      (op),
        .A_in       (a),
        .B_in       (b),
        .WriteHI_in (write_hi),
        .WriteLO_in (write_lo),
        .Data_in    (data),
        .Busy_out   (busy),
        .Done_out   (done),
        .HI_out     (hi),
        .LO_out     (lo)
    );

    always #5 clk = ~clk;

    // Architectural result {HI, LO} from plain integer arithmetic.
    function automatic logic [63:0] model(input logic [1:0] mop, input logic [31:0] ma, input logic [31:0] mb);
        longint p;
        int sa, sb, q, r;
        case (mop)
            2'b00: begin
                p = longint'($signed(ma)) * longint'($signed(mb));
                return p;
            end
            2'b01: return {32'b0, ma} * {32'b0, mb};
            2'b10: begin
                if (mb == 0) return {ma, 32'hFFFF_FFFF};
                if (ma == 32'h8000_0000 && mb == 32'hFFFF_FFFF) return {32'h0, 32'h8000_0000};
                sa = $signed(ma);
                sb = $signed(mb);
                q = sa / sb;
                r = sa % sb;
                return {r, q};
            end
            default: begin
                if (mb == 0) return {ma, 32'hFFFF_FFFF};
                return {ma % mb, ma / mb};
            end
        endcase
    endfunction

    // Called at a negedge; returns at the negedge after the accept edge with
    // the operands scrambled so late changes would show up in the result.
    task automatic start_op(input logic [1:0] sop, input logic [31:0] sa, input logic [31:0] sb);
        start = 1'b1;
        op = sop;
        a = sa;
        b = sb;
        @(negedge clk);
        start = 1'b0;
        op = 2'($urandom_range(0, 3));
        a = $urandom;
        b = $urandom;
    endtask

    // Follows an operation to completion, optionally injecting a Start/MTHI
    // while busy and optionally issuing a new Start in the Done cycle.
    task automatic finish_op(input logic [31:0] exp_hi, input logic [31:0] exp_lo, input string name,
                             input int inject_at, input bit chain,
                             input logic [1:0] cop, input logic [31:0] ca, input logic [31:0] cb);
        logic [31:0] hi0, lo0;
        int n;
        bit hold_bad;
        hi0 = hi;
        lo0 = lo;
        n = 0;
        hold_bad = 1'b0;
        while (busy === 1'b1 && n < 100) begin
            n++;
            if (hi !== hi0 || lo !== lo0 || done !== 1'b0) hold_bad = 1'b1;
            if (n == inject_at) begin
                start = 1'b1; op = 2'b11; a = 32'd9; b = 32'd2;
                write_hi = 1'b1; data = 32'h0000_AAAA;
            end else begin
                start = 1'b0;
                write_hi = 1'b0;
            end
            @(negedge clk);
        end
        checks++;
        if (n !== 33) begin
            errors++;
            $display("FAIL %s busy_cycles: got %0d expected 33", name, n);
        end
        checks++;
        if (hold_bad !== 1'b0) begin
            errors++;
            $display("FAIL %s hold: HI/LO or Done changed while busy (HI0=%h LO0=%h)", name, hi0, lo0);
        end
        checks++;
        if (done !== 1'b1) begin
            errors++;
            $display("FAIL %s done_pulse: got %b expected 1", name, done);
        end
        checks++;
        if ({hi, lo} !== {exp_hi, exp_lo}) begin
            errors++;
            $display("FAIL %s result: got HI=%h LO=%h expected HI=%h LO=%h", name, hi, lo, exp_hi, exp_lo);
        end
        if (chain) begin
            start = 1'b1; op = cop; a = ca; b = cb;
        end
        @(negedge clk);
        start = 1'b0;
        a = $urandom;
        b = $urandom;
        checks++;
        if (done !== 1'b0) begin
            errors++;
            $display("FAIL %s done_width: got %b expected 0", name, done);
        end
        if (chain) begin
            checks++;
            if (busy !== 1'b1) begin
                errors++;
                $display("FAIL %s chain_accept: busy got %b expected 1", name, busy);
            end
        end
    endtask

    task automatic test_reset;
        reset = 1'b1;
        repeat (2) @(negedge clk);
        checks++;
        if ({busy, done, hi, lo} !== 66'b0) begin
            errors++;
            $display("FAIL reset_state: got busy=%b done=%b HI=%h LO=%h expected all 0", busy, done, hi, lo);
        end
        reset = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_directed;
        start_op(2'b01, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
        finish_op(32'hFFFF_FFFE, 32'h0000_0001, "multu_max", 0, 1'b0, 2'b00, 0, 0);
        start_op(2'b00, 32'hFFFF_FFFD, 32'd5);
        finish_op(32'hFFFF_FFFF, 32'hFFFF_FFF1, "mult_neg", 0, 1'b0, 2'b00, 0, 0);
        start_op(2'b10, 32'hFFFF_FFF9, 32'd2);
        finish_op(32'hFFFF_FFFF, 32'hFFFF_FFFD, "div_neg", 0, 1'b0, 2'b00, 0, 0);
        start_op(2'b11, 32'd100, 32'd7);
        finish_op(32'd2, 32'd14, "divu_small", 0, 1'b0, 2'b00, 0, 0);
        start_op(2'b10, 32'h8000_0000, 32'hFFFF_FFFF);
        finish_op(32'h0, 32'h8000_0000, "div_overflow", 0, 1'b0, 2'b00, 0, 0);
        start_op(2'b11, 32'h1234_5678, 32'h0);
        finish_op(32'h1234_5678, 32'hFFFF_FFFF, "divu_by_zero", 0, 1'b0, 2'b00, 0, 0);
        start_op(2'b10, 32'hFFFF_FF00, 32'h0);
        finish_op(32'hFFFF_FF00, 32'hFFFF_FFFF, "div_by_zero", 0, 1'b0, 2'b00, 0, 0);
    endtask

    task automatic test_random;
        logic [1:0]  rop;
        logic [31:0] ra, rb;
        logic [63:0] exp;
        for (int i = 0; i < 24; i++) begin
            rop = 2'($urandom_range(0, 3));
            ra = $urandom;
            rb = $urandom;
            case ($urandom_range(0, 7))
                0: rb = 32'h0;
                1: rb = $urandom_range(1, 15);
                2: begin ra = 32'h8000_0000; rb = 32'hFFFF_FFFF; end
                3: ra = $urandom_range(0, 255);
                4: rb = -($urandom_range(1, 15));
                default: ;
            endcase
            exp = model(rop, ra, rb);
            start_op(rop, ra, rb);
            finish_op(exp[63:32], exp[31:0], $sformatf("random%0d_op%0d", i, rop), 0, 1'b0, 2'b00, 0, 0);
        end
    endtask

    task automatic test_back_to_back;
        start_op(2'b01, 32'd6, 32'd7);
        finish_op(32'h0, 32'd42, "busy_ignore", 10, 1'b1, 2'b11, 32'd100, 32'd7);
        finish_op(32'd2, 32'd14, "chained_divu", 0, 1'b0, 2'b00, 0, 0);
    endtask

    task automatic test_mthi_mtlo;
        logic [31:0] d;
        d = $urandom;
        write_hi = 1'b1; write_lo = 1'b1; data = d;
        @(negedge clk);
        write_hi = 1'b0; write_lo = 1'b0;
        checks++;
        if ({hi, lo} !== {d, d}) begin
            errors++;
            $display("FAIL mthi_mtlo_both: got HI=%h LO=%h expected %h", hi, lo, d);
        end
        d = $urandom;
        write_hi = 1'b1; data = d;
        start = 1'b1; op = 2'b01; a = 32'd3; b = 32'd4;
        @(negedge clk);
        write_hi = 1'b0; start = 1'b0;
        checks++;
        if (hi !== d) begin
            errors++;
            $display("FAIL mthi_with_start: got HI=%h expected %h", hi, d);
        end
        finish_op(32'h0, 32'd12, "start_after_mthi", 0, 1'b0, 2'b00, 0, 0);
    endtask

    task automatic test_reset_midop;
        bit saw_done;
        start_op(2'b00, 32'h7654_3210, 32'hFEDC_BA98);
        repeat (14) @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        checks++;
        if ({busy, done, hi, lo} !== 66'b0) begin
            errors++;
            $display("FAIL reset_midop: got busy=%b done=%b HI=%h LO=%h expected all 0", busy, done, hi, lo);
        end
        saw_done = 1'b0;
        for (int i = 0; i < 40; i++) begin
            if (done !== 1'b0 || busy !== 1'b0) saw_done = 1'b1;
            @(negedge clk);
        end
        checks++;
        if (saw_done !== 1'b0) begin
            errors++;
            $display("FAIL reset_no_done: got activity after reset expected none");
        end
        write_lo = 1'b1; data = 32'h55;
        @(negedge clk);
        write_lo = 1'b0;
        checks++;
        if ({hi, lo} !== {32'h0, 32'h55}) begin
            errors++;
            $display("FAIL idle_mtlo: got HI=%h LO=%h expected HI=0 LO=55", hi, lo);
        end
    endtask

    initial begin
        @(negedge clk);
        test_reset;
        test_directed;
        test_random;
        test_back_to_back;
        test_mthi_mtlo;
        test_reset_midop;
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
